// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding and strobe constants for the stall controller
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      I_MISS = 2'd1,
      D_MISS = 2'd2,
      TRAP   = 2'd3
   } stall_state_t;

   localparam logic [2:0] RES_SRC_LOAD = 3'b001;

   // Stall vector order is {f, d, e, m, wb}; flush vector order is {d, e, m}.
   localparam logic [4:0] STALL_NONE = 5'b00000;
   localparam logic [4:0] STALL_ALL  = 5'b11111;
   localparam logic [4:0] STALL_F    = 5'b10000;
   localparam logic [4:0] STALL_FD   = 5'b11000;

   localparam logic [2:0] FLUSH_NONE = 3'b000;
   localparam logic [2:0] FLUSH_D    = 3'b100;
   localparam logic [2:0] FLUSH_E    = 3'b010;
   localparam logic [2:0] FLUSH_DE   = 3'b110;
   localparam logic [2:0] FLUSH_DEM  = 3'b111;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_arst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count
);

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         o_count <= '0;
      end else if (i_clr) begin
         o_count <= '0;
      end else if (i_inc && (o_count != {CNT_W{1'b1}})) begin
         o_count <= o_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - per-stage stall/flush sequencer for the five-stage pipeline
module pipeline_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_instr_miss,
   input  logic                  i_instr_fill_done,
   input  logic                  i_data_miss,
   input  logic                  i_data_fill_done,
   input  logic [REG_ADDR_W-1:0] i_rs1_addr_d,
   input  logic [REG_ADDR_W-1:0] i_rs2_addr_d,
   input  logic [REG_ADDR_W-1:0] i_rd_addr_e,
   input  logic [2:0]            i_result_src_e,
   input  logic                  i_reg_we_e,
   input  logic                  i_branch_mispred_e,
   input  logic                  i_ecall_wb,
   input  logic                  i_cnt_clr,
   output logic                  o_stall_f,
   output logic                  o_stall_d,
   output logic                  o_stall_e,
   output logic                  o_stall_m,
   output logic                  o_stall_wb,
   output logic                  o_flush_d,
   output logic                  o_flush_e,
   output logic                  o_flush_m,
   output logic                  o_trap_redirect,
   output logic [1:0]            o_state,
   output logic [CNT_W-1:0]      o_stall_cycles
);

   stall_state_t state, state_nxt;
   logic         instr_pend, instr_pend_nxt;
   logic         instr_done, instr_done_nxt;
   logic         load_use;
   logic [4:0]   stall;
   logic [2:0]   flush;
   logic         trap;

   assign load_use = i_reg_we_e && (i_result_src_e == RES_SRC_LOAD) && (i_rd_addr_e != '0) &&
                     ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state      <= RUN;
         instr_pend <= 1'b0;
         instr_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         instr_pend <= instr_pend_nxt;
         instr_done <= instr_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      instr_pend_nxt = instr_pend;
      instr_done_nxt = instr_done;
      stall          = STALL_NONE;
      flush          = FLUSH_NONE;
      trap           = 1'b0;
      unique case (state)
         RUN: begin
            if (i_ecall_wb) begin
               flush     = FLUSH_DEM;
               trap      = 1'b1;
               state_nxt = TRAP;
            end else if (i_data_miss) begin
               stall     = STALL_ALL;
               state_nxt = D_MISS;
            end else if (i_instr_miss) begin
               stall     = STALL_F;
               flush     = FLUSH_D;
               state_nxt = I_MISS;
            end else if (i_branch_mispred_e) begin
               flush = FLUSH_DE;
            end else if (load_use) begin
               stall = STALL_FD;
               flush = FLUSH_E;
            end
         end
         I_MISS: begin
            if (i_ecall_wb) begin
               flush     = FLUSH_DEM;
               trap      = 1'b1;
               state_nxt = TRAP;
            end else if (i_data_miss) begin
               // Park the instruction miss; remember whether its refill already landed.
               stall          = STALL_ALL;
               instr_pend_nxt = 1'b1;
               instr_done_nxt = i_instr_fill_done;
               state_nxt      = D_MISS;
            end else begin
               stall = STALL_F;
               flush = i_branch_mispred_e ? FLUSH_DE : FLUSH_D;
               if (i_instr_fill_done) begin
                  state_nxt = RUN;
               end
            end
         end
         D_MISS: begin
            stall = STALL_ALL;
            if (i_instr_fill_done) begin
               instr_done_nxt = 1'b1;
            end
            if (i_data_fill_done) begin
               state_nxt      = (instr_pend && !(instr_done || i_instr_fill_done)) ? I_MISS : RUN;
               instr_pend_nxt = 1'b0;
               instr_done_nxt = 1'b0;
            end
         end
         TRAP: begin
            flush     = FLUSH_DEM;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
      if (i_arst) begin
         stall = STALL_NONE;
         flush = FLUSH_NONE;
         trap  = 1'b0;
      end
   end

   assign {o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_stall_wb} = stall;
   assign {o_flush_d, o_flush_e, o_flush_m}                        = flush;
   assign o_trap_redirect                                          = trap;
   assign o_state                                                  = state;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .i_clk   (i_clk),
      .i_arst  (i_arst),
      .i_inc   (|stall),
      .i_clr   (i_cnt_clr),
      .o_count (o_stall_cycles)
   );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed and randomized check of pipeline_stall_ctrl against a behavioural model
module tb_pipeline_stall_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int CW = 4;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic          instr_miss = 0, instr_fill_done = 0, data_miss = 0, data_fill_done = 0;
   logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
   logic [2:0]    res_src = '0;
   logic          reg_we = 0, mispred = 0, ecall = 0, cnt_clr = 0;
   logic          stall_f, stall_d, stall_e, stall_m, stall_wb;
   logic          flush_d, flush_e, flush_m, trap_redirect;
   logic [1:0]    state;
   logic [CW-1:0] stall_cycles;

   always #5 clk = ~clk;

   pipeline_stall_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .i_clk(clk), .i_arst(arst),
      .i_instr_miss(instr_miss), .i_instr_fill_done(instr_fill_done),
      .i_data_miss(data_miss), .i_data_fill_done(data_fill_done),
      .i_rs1_addr_d(rs1), .i_rs2_addr_d(rs2), .i_rd_addr_e(rd),
      .i_result_src_e(res_src), .i_reg_we_e(reg_we),
      .i_branch_mispred_e(mispred), .i_ecall_wb(ecall), .i_cnt_clr(cnt_clr),
      .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e),
      .o_stall_m(stall_m), .o_stall_wb(stall_wb),
      .o_flush_d(flush_d), .o_flush_e(flush_e), .o_flush_m(flush_m),
      .o_trap_redirect(trap_redirect), .o_state(state), .o_stall_cycles(stall_cycles)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Behavioural model: what the pipeline is waiting on, described as service flags.
   bit m_trap, m_dwait, m_iwait, m_ideferred, m_ifilled;
   int m_cnt;

   task automatic model_reset();
      m_trap = 0; m_dwait = 0; m_iwait = 0; m_ideferred = 0; m_ifilled = 0; m_cnt = 0;
   endtask

   task automatic step(input string tag);
      logic [4:0] est;
      logic [2:0] efl;
      logic       etr, lu;
      logic [1:0] es;
      bit n_trap, n_dwait, n_iwait, n_idef, n_ifill;
      @(negedge clk);
      est = 5'b0; efl = 3'b0; etr = 1'b0;
      n_trap = 0; n_dwait = m_dwait; n_iwait = m_iwait; n_idef = m_ideferred; n_ifill = m_ifilled;
      lu = reg_we && res_src == 3'b001 && rd != 0 && (rd == rs1 || rd == rs2);
      es = m_trap ? 2'd3 : m_dwait ? 2'd2 : m_iwait ? 2'd1 : 2'd0;
      if (m_trap) begin
         efl = 3'b111;
      end else if (m_dwait) begin
         est = 5'b11111;
         if (instr_fill_done) n_ifill = 1;
         if (data_fill_done) begin
            n_dwait = 0;
            n_iwait = m_ideferred && !(m_ifilled || instr_fill_done);
            n_idef  = 0;
            n_ifill = 0;
         end
      end else if (ecall) begin
         efl = 3'b111; etr = 1; n_trap = 1; n_iwait = 0;
      end else if (data_miss) begin
         est = 5'b11111; n_dwait = 1;
         if (m_iwait) begin
            n_idef = 1; n_iwait = 0; n_ifill = instr_fill_done;
         end
      end else if (m_iwait) begin
         est = 5'b10000;
         efl = mispred ? 3'b110 : 3'b100;
         if (instr_fill_done) n_iwait = 0;
      end else if (instr_miss) begin
         est = 5'b10000; efl = 3'b100; n_iwait = 1;
      end else if (mispred) begin
         efl = 3'b110;
      end else if (lu) begin
         est = 5'b11000; efl = 3'b010;
      end
      check({tag, "_stall"}, 32'({stall_f, stall_d, stall_e, stall_m, stall_wb}), 32'(est));
      check({tag, "_flush"}, 32'({flush_d, flush_e, flush_m}), 32'(efl));
      check({tag, "_trap"}, 32'(trap_redirect), 32'(etr));
      check({tag, "_state"}, 32'(state), 32'(es));
      check({tag, "_cnt"}, 32'(stall_cycles), 32'(m_cnt));
      m_trap = n_trap; m_dwait = n_dwait; m_iwait = n_iwait; m_ideferred = n_idef; m_ifilled = n_ifill;
      if (cnt_clr) m_cnt = 0;
      else if (est != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr_miss = 0; instr_fill_done = 0; data_miss = 0; data_fill_done = 0;
      rs1 = '0; rs2 = '0; rd = '0; res_src = '0; reg_we = 0; mispred = 0; ecall = 0; cnt_clr = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_outs"}, 32'({stall_f, stall_d, stall_e, stall_m, stall_wb,
                                 flush_d, flush_e, flush_m, trap_redirect}), 32'd0);
      check({tag, "_state"}, 32'(state), 32'(RUN));
      check({tag, "_cnt"}, 32'(stall_cycles), 32'd0);
   endtask

   initial begin
      model_reset();
      idle();
      data_miss = 1;
      ecall = 1;
      #2;
      check_reset_outputs("por");
      @(negedge clk);
      arst = 0;
      idle();
      @(posedge clk);
      #1;

      // 3: four-cycle data miss, fill on the fourth
      for (int i = 0; i < 4; i++) begin
         data_miss = 1;
         data_fill_done = (i == 3);
         step("t3_dmiss");
      end
      idle();
      check("t3_state", 32'(state), 32'(RUN));
      check("t3_cnt", 32'(stall_cycles), 32'd4);
      step("t3_after");

      // 1: asynchronous reset while parked in D_MISS
      data_miss = 1;
      step("t1_enter");
      step("t1_hold");
      arst = 1;
      #1;
      check_reset_outputs("t1_rst");
      @(negedge clk);
      arst = 0;
      model_reset();
      idle();
      @(posedge clk);
      #1;

      // 2: load-use on rs2, then the same with x0
      reg_we = 1; res_src = RES_SRC_LOAD; rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5;
      step("t2_lu");
      idle();
      step("t2_idle");
      reg_we = 1; res_src = RES_SRC_LOAD; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      step("t2_x0");
      idle();

      // 4: instruction refill lands while a data miss is being serviced
      instr_miss = 1;
      step("t4_imiss");
      data_miss = 1;
      step("t4_dmiss");
      instr_fill_done = 1;
      step("t4_ifill");
      idle();
      data_miss = 1; data_fill_done = 1;
      step("t4_dfill");
      idle();
      check("t4_state", 32'(state), 32'(RUN));
      step("t4_run");

      // 5: ecall outranks a simultaneous data miss and mispredict
      ecall = 1; data_miss = 1; mispred = 1;
      step("t5_ecall");
      step("t5_trap");
      idle();
      check("t5_state", 32'(state), 32'(RUN));
      step("t5_run");

      // 6: saturation and clear-beats-increment
      cnt_clr = 1;
      step("t6_clr0");
      cnt_clr = 0;
      data_miss = 1;
      for (int i = 0; i < 20; i++) step("t6_sat");
      check("t6_sat15", 32'(stall_cycles), 32'd15);
      cnt_clr = 1;
      step("t6_clr");
      cnt_clr = 0;
      check("t6_zero", 32'(stall_cycles), 32'd0);
      data_fill_done = 1;
      step("t6_fill");
      idle();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         ecall           = !m_dwait && ($urandom_range(0, 15) == 0);
         data_miss       = ($urandom_range(0, 7) == 0);
         data_fill_done  = ($urandom_range(0, 3) == 0);
         instr_miss      = ($urandom_range(0, 5) == 0);
         instr_fill_done = ($urandom_range(0, 3) == 0);
         mispred         = ($urandom_range(0, 7) == 0);
         rs1             = 5'($urandom_range(0, 3));
         rs2             = 5'($urandom_range(0, 3));
         rd              = 5'($urandom_range(0, 3));
         res_src         = ($urandom_range(0, 1) == 1) ? RES_SRC_LOAD : 3'($urandom_range(0, 7));
         reg_we          = ($urandom_range(0, 3) != 0);
         cnt_clr         = ($urandom_range(0, 31) == 0);
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
